// File: rtl/conv_pkg.sv
// Shared constants and the packed result-word type for the result packer.
package conv_pkg;

  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = 16;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned FIFO_DEPTH = 2;

  localparam int unsigned LANE_W = $clog2(WORD_BYTES);
  localparam int unsigned TAG_W  = ADDR_W - LANE_W;
  localparam int unsigned DATA_W = BYTE_W * WORD_BYTES;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [WORD_BYTES-1:0] mask;
    logic [TAG_W-1:0]      tag;
  } word_t;

  localparam int unsigned WORD_W = $bits(word_t);

  // Writes one byte into its lane and marks that lane present.
  function automatic word_t add_byte(input word_t w, input logic [LANE_W-1:0] lane,
                                     input logic [BYTE_W-1:0] b);
    word_t r;
    r = w;
    r.data[{lane, 3'b000} +: BYTE_W] = b;
    r.mask[lane] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding completed result words for one channel.
module result_fifo
  import conv_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_word,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_word,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_word = store[rd_ptr];
  assign do_pop   = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same edge.
  assign do_push  = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_word;
        wr_ptr        <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_packer.sv
// Packs per-channel result bytes into 16-byte words and arbitrates them
// round-robin onto a single wide result-memory write port.
module result_packer
  import conv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_we_0,
  input  logic         in_we_1,
  input  logic         in_we_2,
  input  logic [15:0]  in_addr_0,
  input  logic [15:0]  in_addr_1,
  input  logic [15:0]  in_addr_2,
  input  logic [7:0]   in_data_0,
  input  logic [7:0]   in_data_1,
  input  logic [7:0]   in_data_2,
  input  logic         flush,
  output logic         mem_we,
  output logic [1:0]   mem_sel,
  output logic [11:0]  mem_addr,
  output logic [127:0] mem_data,
  output logic [15:0]  mem_be,
  output logic         busy,
  output logic         overflow
);

  logic              ch_we     [NUM_CH];
  logic [ADDR_W-1:0] ch_addr   [NUM_CH];
  logic [BYTE_W-1:0] ch_data   [NUM_CH];

  word_t             acc_q     [NUM_CH];
  word_t             acc_d     [NUM_CH];
  logic              acc_vld_q [NUM_CH];
  logic              acc_vld_d [NUM_CH];
  word_t             merged    [NUM_CH];
  word_t             opened    [NUM_CH];

  logic              push      [NUM_CH];
  word_t             push_word [NUM_CH];
  logic              pop       [NUM_CH];
  word_t             head      [NUM_CH];
  logic              full      [NUM_CH];
  logic              empty     [NUM_CH];

  logic              drop_any;
  logic [1:0]        last_q;
  logic              gnt_vld;
  logic [1:0]        gnt_ch;

  assign ch_we[0]   = in_we_0;
  assign ch_we[1]   = in_we_1;
  assign ch_we[2]   = in_we_2;
  assign ch_addr[0] = in_addr_0;
  assign ch_addr[1] = in_addr_1;
  assign ch_addr[2] = in_addr_2;
  assign ch_data[0] = in_data_0;
  assign ch_data[1] = in_data_1;
  assign ch_data[2] = in_data_2;

  // Candidate words: incoming byte merged into the open word, or opening a new one.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      merged[c]     = add_byte(acc_q[c], ch_addr[c][LANE_W-1:0], ch_data[c]);
      opened[c]     = '0;
      opened[c].tag = ch_addr[c][ADDR_W-1:LANE_W];
      opened[c]     = add_byte(opened[c], ch_addr[c][LANE_W-1:0], ch_data[c]);
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      acc_d[c]     = acc_q[c];
      acc_vld_d[c] = acc_vld_q[c];
      push[c]      = 1'b0;
      push_word[c] = acc_q[c];
      if (ch_we[c]) begin
        if (acc_vld_q[c] && (acc_q[c].tag == ch_addr[c][ADDR_W-1:LANE_W])) begin
          if ((&merged[c].mask) || flush) begin
            push[c]      = 1'b1;
            push_word[c] = merged[c];
            acc_d[c]     = '0;
            acc_vld_d[c] = 1'b0;
          end else begin
            acc_d[c] = merged[c];
          end
        end else if (acc_vld_q[c]) begin
          // Only one word can leave per edge: the old word goes out, and the
          // newly opened word stays pending even when flush is asserted.
          push[c]      = 1'b1;
          push_word[c] = acc_q[c];
          acc_d[c]     = opened[c];
          acc_vld_d[c] = 1'b1;
        end else if (flush) begin
          push[c]      = 1'b1;
          push_word[c] = opened[c];
          acc_d[c]     = '0;
          acc_vld_d[c] = 1'b0;
        end else begin
          acc_d[c]     = opened[c];
          acc_vld_d[c] = 1'b1;
        end
      end else if (acc_vld_q[c] && flush) begin
        push[c]      = 1'b1;
        acc_d[c]     = '0;
        acc_vld_d[c] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    result_fifo #(
      .WIDTH(WORD_W),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[g]),
      .push_word(push_word[g]),
      .pop      (pop[g]),
      .pop_word (head[g]),
      .full     (full[g]),
      .empty    (empty[g])
    );
  end

  // Round-robin scan starts one past the most recently granted channel.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_ch  = last_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pop[c] = 1'b0;
    end
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = (32'(last_q) + k) % NUM_CH;
      if (!gnt_vld && !empty[idx]) begin
        gnt_vld  = 1'b1;
        gnt_ch   = 2'(idx);
        pop[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    drop_any = 1'b0;
    busy     = mem_we;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      drop_any = drop_any | (push[c] & full[c] & ~pop[c]);
      busy     = busy | acc_vld_q[c] | ~empty[c];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_q[c]     <= '0;
        acc_vld_q[c] <= 1'b0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_q[c]     <= acc_d[c];
        acc_vld_q[c] <= acc_vld_d[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q   <= 2'(NUM_CH - 1);
      overflow <= 1'b0;
      mem_we   <= 1'b0;
      mem_sel  <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_be   <= '0;
    end else begin
      if (drop_any) begin
        overflow <= 1'b1;
      end
      mem_we <= gnt_vld;
      if (gnt_vld) begin
        last_q   <= gnt_ch;
        mem_sel  <= gnt_ch;
        mem_addr <= head[gnt_ch].tag;
        mem_data <= head[gnt_ch].data;
        mem_be   <= head[gnt_ch].mask;
      end
    end
  end

endmodule
